// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
//   Packs symbolic operations (mnemonic + register/immediate fields) into 9-bit
//   machine words and writes them sequentially into instruction memory,
//   starting from a programmable base address.
//
// Ports
//   Clk, Reset           clock, synchronous active-high reset
//   start, base_addr     open (or restart) a load session at base_addr
//   finish               close the session; done pulses one cycle later
//   op_valid/op_ready    operation handshake
//   op_code/ra/rb/imm    symbolic operation fields
//   im_we/addr/wdata     instruction memory write port (one cycle after accept)
//   count                words written this session
//   full                 last memory word written; further ops refused
//   err                  sticky: an illegal op_code was consumed this session
//   done                 one-cycle pulse after the session closes
module instr_encoder_loader #(
    parameter int unsigned PROG_DEPTH = 256,
    parameter int unsigned ADDR_W     = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              finish,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [3:0]        op_code,
    input  logic [2:0]        op_ra,
    input  logic [2:0]        op_rb,
    input  logic [4:0]        op_imm,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [8:0]        im_wdata,
    output logic [ADDR_W-1:0] count,
    output logic              full,
    output logic              err,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(PROG_DEPTH - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StFull} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic              err_q, err_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [8:0]        wdata_q, wdata_d;
    logic              done_q, done_d;

    logic       accept;
    logic       legal;
    logic       write_en;
    logic       at_last;
    logic [8:0] enc_word;

    // ------------------------------------------------------------------
    // State register and datapath flops
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            err_q   <= err_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs decoded from state (op_ready never depends on op_valid)
    // ------------------------------------------------------------------
    always_comb begin
        op_ready = (state_q == StLoad) && !start;
        full     = (state_q == StFull);
    end

    always_comb begin
        accept   = op_valid && op_ready;
        legal    = (op_code <= 4'd11);
        write_en = accept && legal;
        at_last  = (addr_q == LastAddr);
    end

    // ------------------------------------------------------------------
    // Next state; start overrides everything, including a same-cycle finish
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = StLoad;
        end else begin
            unique case (state_q)
                StIdle: state_d = StIdle;
                StLoad: begin
                    // finish takes priority over reaching the last word
                    if (finish) begin
                        state_d = StIdle;
                    end else if (write_en && at_last) begin
                        state_d = StFull;
                    end
                end
                StFull: begin
                    if (finish) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Encoder: w[8:6] class, w[5] sub-select
    // ------------------------------------------------------------------
    always_comb begin
        case (op_code)
            4'd0, 4'd1,
            4'd2, 4'd3: enc_word = {op_code[2:0], op_ra, op_rb};
            4'd4:       enc_word = {3'b100, 1'b0, op_imm};          // ADDI
            4'd5:       enc_word = {3'b100, 1'b1, op_imm};          // LSL
            4'd6:       enc_word = {3'b101, 1'b0, op_imm};          // LSR
            4'd7:       enc_word = {3'b101, 1'b1, op_imm};          // PM
            4'd8:       enc_word = {3'b110, 1'b0, op_imm};          // ADD
            4'd9:       enc_word = {3'b110, 1'b1, op_imm};          // XOR
            4'd10:      enc_word = {3'b111, 1'b0, op_imm};          // BEQR
            4'd11:      enc_word = {3'b111, 1'b1, op_ra[1:0], op_rb}; // COPY
            default:    enc_word = 9'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        addr_d  = addr_q;
        count_d = count_q;
        err_d   = err_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        if (start) begin
            addr_d  = base_addr;
            count_d = '0;
            err_d   = 1'b0;
        end else begin
            if (write_en) begin
                we_d    = 1'b1;
                waddr_d = addr_q;
                wdata_d = enc_word;
                count_d = count_q + ADDR_W'(1);
                // Address parks on the last word; FULL blocks further writes
                if (!at_last) addr_d = addr_q + ADDR_W'(1);
            end
            if (accept && !legal) err_d = 1'b1;
            if (finish && (state_q != StIdle)) done_d = 1'b1;
        end
    end

    always_comb begin
        im_we    = we_q;
        im_addr  = waddr_q;
        im_wdata = wdata_q;
        count    = count_q;
        err      = err_q;
        done     = done_q;
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;

    localparam int DEPTH = 256;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       start;
    logic [7:0] base_addr;
    logic       finish;
    logic       op_valid;
    logic       op_ready;
    logic [3:0] op_code;
    logic [2:0] op_ra;
    logic [2:0] op_rb;
    logic [4:0] op_imm;
    logic       im_we;
    logic [7:0] im_addr;
    logic [8:0] im_wdata;
    logic [7:0] count;
    logic       full;
    logic       err;
    logic       done;

    int checks = 0;
    int errors = 0;

    // Reference model: session mode, cursor, counters and the expected write
    int         m_mode;   // 0 idle, 1 loading, 2 full
    int         m_addr;
    int         m_count;
    bit         m_err;
    bit         m_we;
    int         m_waddr;
    logic [8:0] m_wdata;
    bit         m_done;

    instr_encoder_loader #(
        .PROG_DEPTH (DEPTH),
        .ADDR_W     (8)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .start     (start),
        .base_addr (base_addr),
        .finish    (finish),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_code   (op_code),
        .op_ra     (op_ra),
        .op_rb     (op_rb),
        .op_imm    (op_imm),
        .im_we     (im_we),
        .im_addr   (im_addr),
        .im_wdata  (im_wdata),
        .count     (count),
        .full      (full),
        .err       (err),
        .done      (done)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Codes 4..10 pair up as (class, sub) = (4 + (c-4)/2, (c-4)%2)
    function automatic logic [8:0] ref_encode(input int code, input logic [2:0] ra,
                                              input logic [2:0] rb, input logic [4:0] imm);
        int cls;
        int sub;
        if (code < 4) return {3'(code), ra, rb};
        if (code == 11) return {4'b1111, ra[1:0], rb};
        cls = 4 + (code - 4) / 2;
        sub = (code - 4) % 2;
        return {3'(cls), 1'(sub), imm};
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_addr  = 0;
        m_count = 0;
        m_err   = 0;
        m_we    = 0;
        m_waddr = 0;
        m_wdata = '0;
        m_done  = 0;
    endtask

    // One clock cycle: drive, check op_ready, advance model, check outputs
    task automatic step(input logic st, input logic [7:0] base, input logic fin,
                        input logic v, input logic [3:0] code, input logic [2:0] ra,
                        input logic [2:0] rb, input logic [4:0] imm, input logic rst);
        bit rdy;
        Reset     = rst;
        start     = st;
        base_addr = base;
        finish    = fin;
        op_valid  = v;
        op_code   = code;
        op_ra     = ra;
        op_rb     = rb;
        op_imm    = imm;
        #1;
        rdy = (m_mode == 1) && !st;
        check("op_ready", 32'(op_ready), 32'(rdy));
        if (rst) begin
            model_reset();
        end else begin
            m_we   = 0;
            m_done = 0;
            if (st) begin
                m_mode  = 1;
                m_addr  = int'(base);
                m_count = 0;
                m_err   = 0;
            end else if (m_mode != 0) begin
                if (rdy && v) begin
                    if (code < 12) begin
                        m_we    = 1;
                        m_waddr = m_addr;
                        m_wdata = ref_encode(int'(code), ra, rb, imm);
                        m_count++;
                        if (m_addr == DEPTH - 1) m_mode = 2;
                        else m_addr++;
                    end else begin
                        m_err = 1;
                    end
                end
                if (fin) begin
                    m_mode = 0;
                    m_done = 1;
                end
            end
        end
        @(posedge Clk);
        #1;
        check("im_we", 32'(im_we), 32'(m_we));
        if (m_we) begin
            check("im_addr", 32'(im_addr), 32'(m_waddr));
            check("im_wdata", 32'(im_wdata), 32'(m_wdata));
        end
        check("count", 32'(count), 32'(m_count % 256));
        check("err", 32'(err), 32'(m_err));
        check("full", 32'(full), 32'(m_mode == 2));
        check("done", 32'(done), 32'(m_done));
    endtask

    task automatic idle_step();
        step(1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 3'd0, 3'd0, 5'd0, 1'b0);
    endtask

    task automatic op_step(input logic [3:0] code, input logic [2:0] ra, input logic [2:0] rb,
                           input logic [4:0] imm, input logic fin);
        step(1'b0, 8'h00, fin, 1'b1, code, ra, rb, imm, 1'b0);
    endtask

    task automatic start_step(input logic [7:0] base);
        // An op offered alongside start must not be taken
        step(1'b1, base, 1'b0, 1'b1, 4'd8, 3'd1, 3'd1, 5'd9, 1'b0);
    endtask

    initial begin
        Reset = 1'b1; start = 1'b0; base_addr = '0; finish = 1'b0; op_valid = 1'b0;
        op_code = '0; op_ra = '0; op_rb = '0; op_imm = '0;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        check("rst_op_ready", 32'(op_ready), 32'd0);
        check("rst_im_we", 32'(im_we), 32'd0);
        check("rst_im_addr", 32'(im_addr), 32'd0);
        check("rst_im_wdata", 32'(im_wdata), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        Reset = 1'b0;

        // ADD imm=3 at base 0x10
        start_step(8'h10);
        op_step(4'd8, 3'd0, 3'd0, 5'd3, 1'b0);
        check("add_addr", 32'(im_addr), 32'h10);
        check("add_wdata", 32'(im_wdata), 32'h183);
        check("add_count", 32'(count), 32'd1);

        // Back-to-back LW then COPY
        start_step(8'h10);
        op_step(4'd1, 3'd2, 3'd5, 5'd0, 1'b0);
        check("lw_wdata", 32'(im_wdata), 32'h055);
        op_step(4'd11, 3'd1, 3'd3, 5'd0, 1'b0);
        check("copy_addr", 32'(im_addr), 32'h11);
        check("copy_wdata", 32'(im_wdata), 32'h1EB);
        idle_step();

        // Illegal code between two legal ops
        start_step(8'h20);
        op_step(4'd0, 3'd4, 3'd6, 5'd0, 1'b0);
        op_step(4'd13, 3'd0, 3'd0, 5'd0, 1'b0);
        check("illegal_err", 32'(err), 32'd1);
        check("illegal_we", 32'(im_we), 32'd0);
        op_step(4'd9, 3'd0, 3'd0, 5'd17, 1'b0);
        check("after_illegal_addr", 32'(im_addr), 32'h21);
        idle_step();

        // Fill to the end of memory; third op refused
        start_step(8'hFE);
        op_step(4'd4, 3'd0, 3'd0, 5'd1, 1'b0);
        op_step(4'd5, 3'd0, 3'd0, 5'd2, 1'b0);
        check("full_flag", 32'(full), 32'd1);
        check("full_ready", 32'(op_ready), 32'd0);
        op_step(4'd6, 3'd0, 3'd0, 5'd3, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 3'd0, 3'd0, 5'd0, 1'b0);
        check("full_done", 32'(done), 32'd1);
        check("full_count", 32'(count), 32'd2);
        idle_step();

        // finish with an accepted SW
        start_step(8'h40);
        op_step(4'd2, 3'd7, 3'd0, 5'd0, 1'b1);
        check("sw_wdata", 32'(im_wdata), 32'h0B8);
        check("sw_done", 32'(done), 32'd1);
        idle_step();

        // start together with finish: no done
        start_step(8'h50);
        step(1'b1, 8'h60, 1'b1, 1'b0, 4'd0, 3'd0, 3'd0, 5'd0, 1'b0);
        op_step(4'd3, 3'd2, 3'd2, 5'd0, 1'b0);
        check("restart_addr", 32'(im_addr), 32'h60);

        // Reset during a stream drops the pending write
        op_step(4'd7, 3'd0, 3'd0, 5'd5, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 4'd10, 3'd0, 3'd0, 5'd6, 1'b1);
        check("midrst_we", 32'(im_we), 32'd0);
        check("midrst_count", 32'(count), 32'd0);
        idle_step();
        start_step(8'h33);
        op_step(4'd10, 3'd0, 3'd0, 5'd31, 1'b0);
        check("resume_addr", 32'(im_addr), 32'h33);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            logic       r_rst;
            logic       r_st;
            logic [7:0] r_base;
            r_rst  = ($urandom_range(0, 199) == 0);
            r_st   = ($urandom_range(0, 19) == 0);
            r_base = ($urandom_range(0, 2) == 0) ? 8'(8'hF0 + $urandom_range(0, 15))
                                                 : 8'($urandom);
            step(r_st, r_base, ($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0),
                 4'($urandom), 3'($urandom), 3'($urandom), 5'($urandom), r_rst);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
